// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings, base opcodes and funct7 values.
// Used by the ID/EX control stage and by the ALU itself.
package alu_pkg;

    typedef enum logic [3:0] {
        AluAnd     = 4'b0000,
        AluOr      = 4'b0001,
        AluAdd     = 4'b0010,
        AluSub     = 4'b0110,
        AluSll     = 4'b0111,
        AluSrl     = 4'b1000,
        AluSra     = 4'b1001,
        AluXor     = 4'b1010,
        AluIllegal = 4'b1111
    } alu_op_e;

    localparam logic [6:0] OpcodeOp    = 7'b0110011;
    localparam logic [6:0] OpcodeOpImm = 7'b0010011;
    localparam logic [6:0] OpcodeLoad  = 7'b0000011;
    localparam logic [6:0] OpcodeStore = 7'b0100011;

    localparam logic [6:0] Funct7Base = 7'b0000000;
    localparam logic [6:0] Funct7Alt  = 7'b0100000;

endpackage

// File: rtl/id_ex_alu_ctrl_if.sv
// Decode-to-execute bus of the ID/EX ALU control stage.
//   in_valid/in_ready   : decode-side handshake, with instr, rs1_data, rs2_data
//   flush               : kill the held entry (branch redirect)
//   out_valid/out_ready : execute-side handshake, with alu_op, operand1/2, rd,
//                         reg_write, illegal
//   illegal_cnt         : saturating count of accepted illegal instructions
// master = decode/execute environment, slave = the stage itself.
interface id_ex_alu_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            flush;
    logic            out_ready;
    logic            out_valid;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] operand1;
    logic [XLEN-1:0] operand2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            illegal;
    logic [15:0]     illegal_cnt;

    modport master (
        output in_valid, instr, rs1_data, rs2_data, flush, out_ready,
        input  in_ready, out_valid, alu_op, operand1, operand2, rd, reg_write, illegal,
               illegal_cnt
    );

    modport slave (
        input  in_valid, instr, rs1_data, rs2_data, flush, out_ready,
        output in_ready, out_valid, alu_op, operand1, operand2, rd, reg_write, illegal,
               illegal_cnt
    );
endinterface

// File: rtl/imm_gen.sv
// Immediate generator: sign-extended I and S immediates and zero-extended shamt.
//   i_instr   : instruction word
//   o_imm_i   : sign-extended instr[31:20]
//   o_imm_s   : sign-extended {instr[31:25], instr[11:7]}
//   o_shamt   : zero-extended instr[24:20]
module imm_gen #(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm_i,
    output logic [XLEN-1:0] o_imm_s,
    output logic [XLEN-1:0] o_shamt
);
    logic w_unused_instr;

    assign o_imm_i = {{(XLEN - 12){i_instr[31]}}, i_instr[31:20]};
    assign o_imm_s = {{(XLEN - 12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign o_shamt = {{(XLEN - 5){1'b0}}, i_instr[24:20]};

    // rs1/funct3/opcode fields carry no immediate bits
    assign w_unused_instr = ^{i_instr[19:12], i_instr[6:0]};
endmodule

// File: rtl/id_ex_alu_ctrl.sv
// ID/EX ALU control stage: decodes R/I/load/store instructions into an ALU
// operation and operands, held in a single-entry valid/ready pipeline register.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of id_ex_alu_ctrl_if (decode in, execute out)
module id_ex_alu_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input logic             clk,
    input logic             rst,
    id_ex_alu_ctrl_if.slave bus
);
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_shamt;

    alu_op_e         w_alu_op;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    logic [4:0]      w_rd;
    logic            w_wr;
    logic            w_legal;
    logic            w_in_ready;
    logic            w_accept;

    alu_op_e         r_alu_op;
    logic [XLEN-1:0] r_op1;
    logic [XLEN-1:0] r_op2;
    logic [4:0]      r_rd;
    logic            r_reg_write;
    logic            r_illegal;
    logic            r_valid;
    logic [15:0]     r_cnt;

    assign w_opcode = bus.instr[6:0];
    assign w_funct3 = bus.instr[14:12];
    assign w_funct7 = bus.instr[31:25];

    imm_gen #(
        .XLEN(XLEN)
    ) u_imm_gen (
        .i_instr(bus.instr),
        .o_imm_i(w_imm_i),
        .o_imm_s(w_imm_s),
        .o_shamt(w_shamt)
    );

    always_comb begin
        w_alu_op = AluIllegal;
        w_op2    = '0;
        w_wr     = 1'b0;
        w_legal  = 1'b0;
        case (w_opcode)
            OpcodeOp: begin
                w_op2   = bus.rs2_data;
                w_wr    = 1'b1;
                w_legal = 1'b1;
                case ({w_funct7, w_funct3})
                    {Funct7Base, 3'b000}: w_alu_op = AluAdd;
                    {Funct7Alt,  3'b000}: w_alu_op = AluSub;
                    {Funct7Base, 3'b001}: w_alu_op = AluSll;
                    {Funct7Base, 3'b100}: w_alu_op = AluXor;
                    {Funct7Base, 3'b101}: w_alu_op = AluSrl;
                    {Funct7Alt,  3'b101}: w_alu_op = AluSra;
                    {Funct7Base, 3'b110}: w_alu_op = AluOr;
                    {Funct7Base, 3'b111}: w_alu_op = AluAnd;
                    default:              w_legal  = 1'b0;
                endcase
            end
            OpcodeOpImm: begin
                w_op2   = w_imm_i;
                w_wr    = 1'b1;
                w_legal = 1'b1;
                case (w_funct3)
                    3'b000: w_alu_op = AluAdd;
                    3'b100: w_alu_op = AluXor;
                    3'b110: w_alu_op = AluOr;
                    3'b111: w_alu_op = AluAnd;
                    3'b001: begin
                        w_op2    = w_shamt;
                        w_alu_op = AluSll;
                        w_legal  = (w_funct7 == Funct7Base);
                    end
                    3'b101: begin
                        w_op2    = w_shamt;
                        w_alu_op = (w_funct7 == Funct7Alt) ? AluSra : AluSrl;
                        w_legal  = (w_funct7 == Funct7Base) || (w_funct7 == Funct7Alt);
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            OpcodeLoad: begin
                w_alu_op = AluAdd;
                w_op2    = w_imm_i;
                w_wr     = 1'b1;
                w_legal  = 1'b1;
            end
            OpcodeStore: begin
                w_alu_op = AluAdd;
                w_op2    = w_imm_s;
                w_legal  = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
        // An illegal word carries no operation or operands downstream
        if (!w_legal) begin
            w_alu_op = AluIllegal;
            w_op2    = '0;
            w_wr     = 1'b0;
        end
    end

    assign w_op1 = w_legal ? bus.rs1_data : '0;
    assign w_rd  = w_legal ? bus.instr[11:7] : 5'd0;

    assign w_in_ready = !r_valid || bus.out_ready;
    // Flush drops an instruction offered in the same cycle
    assign w_accept   = bus.in_valid && w_in_ready && !bus.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_alu_op    <= AluAnd;
            r_op1       <= '0;
            r_op2       <= '0;
            r_rd        <= 5'd0;
            r_reg_write <= 1'b0;
            r_illegal   <= 1'b0;
            r_cnt       <= 16'd0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid     <= 1'b1;
            r_alu_op    <= w_alu_op;
            r_op1       <= w_op1;
            r_op2       <= w_op2;
            r_rd        <= w_rd;
            r_reg_write <= w_wr && (w_rd != 5'd0);
            r_illegal   <= !w_legal;
            if (!w_legal && (r_cnt != 16'hFFFF)) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end else if (bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_valid;
    assign bus.alu_op      = r_alu_op;
    assign bus.operand1    = r_op1;
    assign bus.operand2    = r_op2;
    assign bus.rd          = r_rd;
    assign bus.reg_write   = r_reg_write;
    assign bus.illegal     = r_illegal;
    assign bus.illegal_cnt = r_cnt;
endmodule
